// File: rtl/fp32_pkg.sv
// Shared FP32 constants, rounding-mode codes, divider FSM encoding and operand classifiers.
// The Multiplier imports the same package.
package fp32_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  localparam logic [1:0] RM_POS_INF = 2'b00;
  localparam logic [1:0] RM_NEG_INF = 2'b01;
  localparam logic [1:0] RM_NEAREST = 2'b10;
  localparam logic [1:0] RM_ZERO    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_DIVIDE,
    ST_ROUND,
    ST_DONE
  } div_state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

  // Denormals carry exponent 0 and are treated as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fp32_div_step.sv
// One restoring division step: subtract the divisor from the partial remainder,
// keep the difference when non-negative, then shift for the next quotient bit.
module fp32_div_step (
  input  logic [24:0] rem_in,
  input  logic [23:0] divisor,
  output logic [24:0] rem_out,
  output logic        q_bit
);

  logic signed [25:0] diff;

  assign diff  = $signed({1'b0, rem_in}) - $signed({2'b00, divisor});
  assign q_bit = ~diff[25];
  // rem_in < 2*divisor, so both the difference and a failed trial fit in 24 bits before the shift.
  assign rem_out = q_bit ? {diff[23:0], 1'b0} : {rem_in[23:0], 1'b0};

endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider, resultDiv = A / B, restoring radix-2 mantissa division
// with STEPS_PER_CYCLE quotient bits per clock and valid/ready on both sides.
module fp32_divider
  import fp32_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] resultDiv,
  output logic        errorDiv,
  output logic        overflowDiv
);

  localparam int DIV_CYCLES = 26 / STEPS_PER_CYCLE;
  localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic rnd, input logic sticky);
    logic inexact;
    inexact = guard | rnd | sticky;
    case (rm)
      RM_POS_INF: return !sign && inexact;
      RM_NEG_INF: return sign && inexact;
      RM_NEAREST: return guard && (rnd || sticky || lsb);
      RM_ZERO:    return 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

  // Returns {overflow, packed result}; underflow flushes to signed zero.
  function automatic logic [32:0] saturate_pack(input logic sign,
                                                input logic signed [9:0] exp,
                                                input logic [22:0] frac);
    if (exp >= 10'sd255)
      return {1'b1, sign, EXP_MAX, 23'd0};
    else if (exp <= 10'sd0)
      return {1'b0, sign, 31'd0};
    else
      return {1'b0, sign, exp[7:0], frac};
  endfunction

  div_state_t         state;
  logic [31:0]        a_p0, b_p0;
  logic [1:0]         rm_p0;
  logic               sign_p0;
  logic [23:0]        m2_p1;
  logic [24:0]        rem_p1;
  logic [25:0]        quo_p1;
  logic signed [9:0]  exp_p1;
  logic [4:0]         cnt_p1;

  // Unpack stage: implicit leading one and biased exponent difference.
  logic [23:0]        m1_u, m2_u;
  logic signed [9:0]  exp_u;

  always_comb begin
    m1_u  = {1'b1, a_p0[22:0]};
    m2_u  = {1'b1, b_p0[22:0]};
    exp_u = $signed({2'b00, a_p0[30:23]}) - $signed({2'b00, b_p0[30:23]}) + BIAS_S;
  end

  // Divide stage: STEPS_PER_CYCLE restoring steps chained in series.
  logic [24:0]                rem_chain [0:STEPS_PER_CYCLE];
  logic [STEPS_PER_CYCLE-1:0] q_chain;

  assign rem_chain[0] = rem_p1;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    fp32_div_step u_step (
      .rem_in  (rem_chain[g]),
      .divisor (m2_p1),
      .rem_out (rem_chain[g+1]),
      .q_bit   (q_chain[STEPS_PER_CYCLE-1-g])
    );
  end

  // Round stage: quo_p1 = 24 mantissa bits, guard, round; remainder gives sticky.
  logic               inc_p2;
  logic [24:0]        mant_sum_p2;
  logic [22:0]        frac_p2;
  logic signed [9:0]  exp_p2;
  logic [32:0]        packed_p2;

  always_comb begin
    inc_p2      = round_inc(rm_p0, sign_p0, quo_p1[2], quo_p1[1], quo_p1[0], |rem_p1);
    mant_sum_p2 = {1'b0, quo_p1[25:2]} + {24'd0, inc_p2};
    if (mant_sum_p2[24]) begin
      frac_p2 = mant_sum_p2[23:1];
      exp_p2  = exp_p1 + 10'sd1;
    end else begin
      frac_p2 = mant_sum_p2[22:0];
      exp_p2  = exp_p1;
    end
    packed_p2 = saturate_pack(sign_p0, exp_p2, frac_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      resultDiv   <= '0;
      errorDiv    <= 1'b0;
      overflowDiv <= 1'b0;
      a_p0        <= '0;
      b_p0        <= '0;
      rm_p0       <= '0;
      sign_p0     <= 1'b0;
      m2_p1       <= '0;
      rem_p1      <= '0;
      quo_p1      <= '0;
      exp_p1      <= '0;
      cnt_p1      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_p0     <= A;
            b_p0     <= B;
            rm_p0    <= round_mode;
            sign_p0  <= A[31] ^ B[31];
            in_ready <= 1'b0;
            state    <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          state       <= ST_DONE;
          errorDiv    <= 1'b0;
          overflowDiv <= 1'b0;
          if (is_nan(a_p0)) begin
            resultDiv <= a_p0;
            errorDiv  <= 1'b1;
          end else if (is_nan(b_p0)) begin
            resultDiv <= b_p0;
            errorDiv  <= 1'b1;
          end else if ((is_zero(a_p0) && is_zero(b_p0)) || (is_inf(a_p0) && is_inf(b_p0))) begin
            resultDiv <= {sign_p0, QNAN[30:0]};
            errorDiv  <= 1'b1;
          end else if (is_inf(a_p0)) begin
            resultDiv <= {sign_p0, EXP_MAX, 23'd0};
          end else if (is_inf(b_p0)) begin
            resultDiv <= {sign_p0, 31'd0};
          end else if (is_zero(b_p0)) begin
            resultDiv <= {sign_p0, EXP_MAX, 23'd0};
            errorDiv  <= 1'b1;
          end else if (is_zero(a_p0)) begin
            resultDiv <= {sign_p0, 31'd0};
          end else begin
            state  <= ST_DIVIDE;
            m2_p1  <= m2_u;
            quo_p1 <= '0;
            cnt_p1 <= 5'(DIV_CYCLES - 1);
            // Pre-scaling the dividend keeps the quotient in [1,2) so its first bit is always 1.
            if (m1_u < m2_u) begin
              rem_p1 <= {m1_u, 1'b0};
              exp_p1 <= exp_u - 10'sd1;
            end else begin
              rem_p1 <= {1'b0, m1_u};
              exp_p1 <= exp_u;
            end
          end
        end
        ST_DIVIDE: begin
          rem_p1 <= rem_chain[STEPS_PER_CYCLE];
          quo_p1 <= {quo_p1[25-STEPS_PER_CYCLE:0], q_chain};
          if (cnt_p1 == 5'd0)
            state <= ST_ROUND;
          else
            cnt_p1 <= cnt_p1 - 5'd1;
        end
        ST_ROUND: begin
          resultDiv   <= packed_p2[31:0];
          overflowDiv <= packed_p2[32];
          errorDiv    <= 1'b0;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          // Special cases arrive here with out_valid low; it rises one cycle later.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// Randomized and directed bench for fp32_divider against an integer long-division reference.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [1:0]  round_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] resultDiv;
  logic        errorDiv;
  logic        overflowDiv;

  int errors = 0;
  int checks = 0;

  fp32_divider #(.STEPS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .resultDiv  (resultDiv),
    .errorDiv   (errorDiv),
    .overflowDiv(overflowDiv)
  );

  always #5 clk = ~clk;

  // Reference: exact integer quotient, then IEEE rounding of the discarded fraction. Returns {err, ovf, result}.
  function automatic logic [33:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    logic s, up, inexact;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    int ea, eb, e, drop;
    longint unsigned ma, mb, q, r, tail, half, mant;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    a_zero = (ea == 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    b_zero = (eb == 0);
    if (a_nan) return {2'b10, a};
    if (b_nan) return {2'b10, b};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {2'b10, s, 31'h7FC00000};
    if (a_inf) return {2'b00, s, 8'hFF, 23'd0};
    if (b_inf) return {2'b00, s, 31'd0};
    if (b_zero) return {2'b10, s, 8'hFF, 23'd0};
    if (a_zero) return {2'b00, s, 31'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q = (ma << 40) / mb;
    r = (ma << 40) % mb;
    e = ea - eb + 127;
    if (q >= (64'd1 << 40)) drop = 17;
    else begin
      drop = 16;
      e = e - 1;
    end
    mant = q >> drop;
    tail = q & ((64'd1 << drop) - 64'd1);
    half = 64'd1 << (drop - 1);
    inexact = (tail != 0) || (r != 0);
    case (rm)
      2'b00: up = !s && inexact;
      2'b01: up = s && inexact;
      2'b10: up = (tail > half) || ((tail == half) && ((r != 0) || mant[0]));
      default: up = 1'b0;
    endcase
    mant = mant + {63'd0, up};
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b00, s, 31'd0};
    return {2'b00, s, e[7:0], mant[22:0]};
  endfunction

  function automatic int model_latency(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 2;
    return 28;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [6];
    logic [31:0] x;
    int sel;
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00123456};
    sel = int'($urandom_range(0, 11));
    x = $urandom;
    if (sel == 0) return specials[$urandom_range(0, 5)];
    if (sel < 7) x[30:23] = 8'($urandom_range(110, 144));
    else x[30:23] = 8'($urandom_range(1, 254));
    return x;
  endfunction

  // Drives one transaction to completion; latency counts edges from accept to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        output logic [33:0] got, output int lat,
                        output logic rdy_after, output logic vld_after);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    A = a;
    B = b;
    round_mode = rm;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    got = {errorDiv, overflowDiv, resultDiv};
    out_ready = 1'b1;
    @(posedge clk);
    #1 rdy_after = in_ready;
    vld_after = out_valid;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (resultDiv !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", resultDiv); end
    checks++;
    if ({errorDiv, overflowDiv} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {errorDiv, overflowDiv}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [33:0] got;
    int lat;
    logic ra, va;
    run_op(32'h40C00000, 32'h40000000, 2'b10, got, lat, ra, va);
    checks++;
    if (got !== {2'b00, 32'h40400000}) begin errors++; $display("FAIL basic_6div2: got %h want %h", got, {2'b00, 32'h40400000}); end
    checks++;
    if (lat !== 28) begin errors++; $display("FAIL basic_latency: got %0d want 28", lat); end
  endtask

  task automatic test_rounding();
    logic [31:0] va [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000};
    logic [1:0]  vr [5] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
    logic [31:0] ve [5] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAA};
    logic [33:0] got;
    int lat;
    logic ra, vv;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], 32'h40400000, vr[i], got, lat, ra, vv);
      checks++;
      if (got !== {2'b00, ve[i]}) begin errors++; $display("FAIL rounding_%0d: got %h want %h", i, got, {2'b00, ve[i]}); end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [9] = '{32'h00000000, 32'h3F800000, 32'h7FC12345, 32'h7F800000, 32'hFF800000,
                            32'h40000000, 32'h80000000, 32'h3F800000, 32'h00400000};
    logic [31:0] vb [9] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'h40000000,
                            32'h7F800000, 32'h40400000, 32'h7FC00001, 32'h3F800000};
    logic [33:0] ve [9] = '{{2'b10, 32'h7FC00000}, {2'b10, 32'h7F800000}, {2'b10, 32'h7FC12345},
                            {2'b10, 32'h7FC00000}, {2'b00, 32'hFF800000}, {2'b00, 32'h00000000},
                            {2'b00, 32'h80000000}, {2'b10, 32'h7FC00001}, {2'b00, 32'h00000000}};
    logic [33:0] got;
    int lat;
    logic ra, vv;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], 2'b10, got, lat, ra, vv);
      checks++;
      if (got !== ve[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, got, ve[i]); end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL special_latency_%0d: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_overflow();
    logic [33:0] got;
    int lat;
    logic ra, vv;
    run_op(32'h7F000000, 32'h00800000, 2'b10, got, lat, ra, vv);
    checks++;
    if (got !== {2'b01, 32'h7F800000}) begin errors++; $display("FAIL overflow: got %h want %h", got, {2'b01, 32'h7F800000}); end
    run_op(32'h00800000, 32'h7F000000, 2'b10, got, lat, ra, vv);
    checks++;
    if (got !== {2'b00, 32'h00000000}) begin errors++; $display("FAIL underflow: got %h want %h", got, {2'b00, 32'h00000000}); end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    round_mode = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        A = 32'h3F800000;
        B = 32'h40400000;
        in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready, resultDiv} !== {2'b10, 32'h40400000}) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b r=%b %h want v=1 r=0 40400000", i, out_valid, in_ready, resultDiv);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL idle_after_%0d: got v=%b r=%b want v=0 r=1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] got;
    int lat;
    logic ra, vv;
    logic [31:0] a, b;
    logic [1:0] rm;
    for (int i = 0; i < 3; i++) begin
      a = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      rm = 2'($urandom);
      run_op(a, b, rm, got, lat, ra, vv);
      checks++;
      if (got !== model_div(a, b, rm)) begin errors++; $display("FAIL b2b_val_%0d: got %h want %h", i, got, model_div(a, b, rm)); end
      checks++;
      if ({ra, vv} !== 2'b10) begin errors++; $display("FAIL b2b_hs_%0d: got r=%b v=%b want r=1 v=0", i, ra, vv); end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] got;
    int lat;
    logic ra, vv;
    @(negedge clk);
    A = 32'h3F800000;
    B = 32'h40400000;
    round_mode = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL midreset_hs: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    checks++;
    if ({errorDiv, overflowDiv, resultDiv} !== 34'd0) begin errors++; $display("FAIL midreset_out: got %h want 0", {errorDiv, overflowDiv, resultDiv}); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, 2'b10, got, lat, ra, vv);
    checks++;
    if (got !== {2'b00, 32'h40400000}) begin errors++; $display("FAIL midreset_next: got %h want %h", got, {2'b00, 32'h40400000}); end
    checks++;
    if (lat !== 28) begin errors++; $display("FAIL midreset_latency: got %0d want 28", lat); end
  endtask

  task automatic test_random();
    logic [33:0] got, exp;
    int lat;
    logic ra, vv;
    logic [31:0] a, b;
    logic [1:0] rm;
    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      rm = 2'($urandom);
      exp = model_div(a, b, rm);
      run_op(a, b, rm, got, lat, ra, vv);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random_%0d %h/%h rm=%0d: got %h want %h", i, a, b, rm, got, exp); end
      checks++;
      if (lat !== model_latency(a, b)) begin errors++; $display("FAIL random_latency_%0d: got %0d want %0d", i, lat, model_latency(a, b)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
